// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the RV immediate, format, illegal flag
// and PC-relative target for one instruction per valid/ready transfer.
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] target;
    } bundle_t;

    logic [31:0]     w_imm32;
    logic            w_fill;
    logic            w_has_target;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    bundle_t         w_dec;
    logic            w_in_fire;

    bundle_t         r_out;
    logic            r_out_valid;

    // w_imm32 holds the low 32 bits; w_fill is replicated above bit 31 for XLEN=64.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_imm32      = '0;
        w_fill       = 1'b0;
        w_has_target = 1'b0;
        w_fmt        = FMT_ILL;
        w_illegal    = 1'b0;
        case (in_inst[6:0])
            OP_R: begin
                w_fmt = FMT_R;
            end
            OP_LOAD, OP_JALR: begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                w_fill  = in_inst[31];
            end
            OP_IMM: begin
                w_fmt = FMT_I;
                if (in_inst[13:12] == 2'b01) begin
                    // Shifts carry a zero-extended shamt, not a signed immediate.
                    if (XLEN == 64) w_imm32 = {26'b0, in_inst[25:20]};
                    else            w_imm32 = {27'b0, in_inst[24:20]};
                end else begin
                    w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    w_fill  = in_inst[31];
                end
            end
            OP_STORE: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_fill  = in_inst[31];
            end
            OP_BRANCH: begin
                w_fmt        = FMT_B;
                w_imm32      = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                                in_inst[11:8], 1'b0};
                w_fill       = in_inst[31];
                w_has_target = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_fmt        = FMT_U;
                w_imm32      = {in_inst[31:12], 12'b0};
                w_fill       = in_inst[31];
                w_has_target = (in_inst[6:0] == OP_AUIPC);
            end
            OP_JAL: begin
                w_fmt        = FMT_J;
                w_imm32      = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                                in_inst[30:21], 1'b0};
                w_fill       = in_inst[31];
                w_has_target = 1'b1;
            end
            default: begin
                w_fmt     = FMT_ILL;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_imm        = {XLEN{w_fill}};
        w_imm[31:0]  = w_imm32;
        w_target     = w_has_target ? (in_pc + w_imm) : '0;
    end

    always_comb begin
        w_dec.inst    = in_inst;
        w_dec.pc      = in_pc;
        w_dec.imm     = w_imm;
        w_dec.fmt     = w_fmt;
        w_dec.illegal = w_illegal;
        w_dec.target  = w_target;
    end

    assign w_in_fire = in_valid & in_ready;

    generate
        if (SKID) begin : g_skid
            bundle_t r_skid;
            logic    r_skid_valid;

            // in_ready depends only on state and rst, never on out_ready.
            assign in_ready = !rst && !r_skid_valid;

            // NOTE: sequential state uses <= so every register samples pre-edge values.
            // NOTE: skid data is reset along with its valid so no X can ever reach out_*.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out        <= '0;
                    r_out_valid  <= 1'b0;
                    r_skid       <= '0;
                    r_skid_valid <= 1'b0;
                end else if (!r_out_valid || out_ready) begin
                    if (r_skid_valid) begin
                        r_out        <= r_skid;
                        r_out_valid  <= 1'b1;
                        r_skid_valid <= 1'b0;
                    end else if (w_in_fire) begin
                        r_out       <= w_dec;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end else if (w_in_fire) begin
                    r_skid       <= w_dec;
                    r_skid_valid <= 1'b1;
                end
            end
        end else begin : g_noskid
            assign in_ready = !rst && (!r_out_valid || out_ready);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out       <= '0;
                    r_out_valid <= 1'b0;
                end else if (!r_out_valid || out_ready) begin
                    r_out_valid <= w_in_fire;
                    if (w_in_fire) r_out <= w_dec;
                end
            end
        end
    endgenerate

    assign out_valid   = r_out_valid;
    assign out_inst    = r_out.inst;
    assign out_pc      = r_out.pc;
    assign out_imm     = r_out.imm;
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.illegal;
    assign out_target  = r_out.target;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 with skid buffer, XLEN=32 without.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] pc32;
    logic [63:0] pc64;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_inst, a_out_pc, a_out_imm, a_out_target;
    logic [2:0]  a_out_fmt;

    logic        d_in_ready, d_out_valid, d_out_illegal;
    logic [31:0] d_out_inst;
    logic [63:0] d_out_pc, d_out_imm, d_out_target;
    logic [2:0]  d_out_fmt;

    logic        s_in_ready, s_out_valid, s_out_illegal;
    logic [31:0] s_out_inst, s_out_pc, s_out_imm, s_out_target;
    logic [2:0]  s_out_fmt;

    int n_checks;
    int n_fail;

    imm_gen_stage #(.XLEN(32), .SKID(1'b1)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(pc32), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_inst(a_out_inst), .out_pc(a_out_pc), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
        .out_illegal(a_out_illegal), .out_target(a_out_target)
    );

    imm_gen_stage #(.XLEN(64), .SKID(1'b1)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_inst(in_inst), .in_pc(pc64), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_inst(d_out_inst), .out_pc(d_out_pc), .out_imm(d_out_imm), .out_fmt(d_out_fmt),
        .out_illegal(d_out_illegal), .out_target(d_out_target)
    );

    imm_gen_stage #(.XLEN(32), .SKID(1'b0)) u_dut_noskid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_inst(in_inst), .in_pc(pc32), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_inst(s_out_inst), .out_pc(s_out_pc), .out_imm(s_out_imm), .out_fmt(s_out_fmt),
        .out_illegal(s_out_illegal), .out_target(s_out_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc);
        in_inst  = inst;
        pc32     = pc[31:0];
        pc64     = pc;
        in_valid = 1'b1;
    endtask

    // Full output check of the XLEN=32 skid instance.
    task automatic chk_a(input string tag, input logic [31:0] inst, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic ill, input logic [31:0] tgt);
        check({tag, ".valid"},   64'(a_out_valid),   64'd1);
        check({tag, ".inst"},    64'(a_out_inst),    64'(inst));
        check({tag, ".imm"},     64'(a_out_imm),     64'(imm));
        check({tag, ".fmt"},     64'(a_out_fmt),     64'(fmt));
        check({tag, ".illegal"}, 64'(a_out_illegal), 64'(ill));
        check({tag, ".target"},  64'(a_out_target),  64'(tgt));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        pc32      = '0;
        pc64      = '0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst.in_ready",   64'(a_in_ready),  64'd0);
        check("rst.out_valid",  64'(a_out_valid), 64'd0);
        check("rst.imm",        64'(a_out_imm),   64'd0);
        check("rst.inst",       64'(a_out_inst),  64'd0);
        check("rst.d64_valid",  64'(d_out_valid), 64'd0);
        check("rst.s0_ready",   64'(s_in_ready),  64'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready",    64'(a_in_ready), 64'd1);
        check("post_rst.d64_ready",   64'(d_in_ready), 64'd1);
        check("post_rst.s0_ready",    64'(s_in_ready), 64'd1);

        // Back-to-back decode vectors, out_ready=1
        drive(32'hFFF00093, 64'h0);
        tick();
        chk_a("addi_m1", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h0);
        check("addi_m1.d64_imm", d_out_imm, 64'hFFFFFFFF_FFFFFFFF);
        check("addi_m1.s0_imm",  64'(s_out_imm), 64'hFFFFFFFF);

        drive(32'h4010D093, 64'h0);
        tick();
        chk_a("srai", 32'h4010D093, 32'h00000001, 3'd1, 1'b0, 32'h0);
        check("srai.d64_imm", d_out_imm, 64'h1);

        drive(32'hFE000EE3, 64'h100);
        tick();
        chk_a("beq_pc100", 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 32'h000000FC);
        check("beq_pc100.pc",      64'(a_out_pc), 64'h100);
        check("beq_pc100.d64_tgt", d_out_target, 64'h00000000_000000FC);

        drive(32'hFE000EE3, 64'h0);
        tick();
        chk_a("beq_pc0", 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC);
        check("beq_pc0.d64_tgt", d_out_target, 64'hFFFFFFFF_FFFFFFFC);
        check("beq_pc0.s0_tgt",  64'(s_out_target), 64'hFFFFFFFC);

        drive(32'h800000B7, 64'h40);
        tick();
        chk_a("lui", 32'h800000B7, 32'h80000000, 3'd4, 1'b0, 32'h0);
        check("lui.d64_imm", d_out_imm, 64'hFFFFFFFF_80000000);
        check("lui.d64_fmt", 64'(d_out_fmt), 64'd4);

        drive(32'h0000007F, 64'h44);
        tick();
        chk_a("illegal", 32'h0000007F, 32'h0, 3'd6, 1'b0 | 1'b1, 32'h0);
        check("illegal.d64_ill", 64'(d_out_illegal), 64'd1);

        drive(32'h00001097, 64'h1000);
        tick();
        chk_a("auipc", 32'h00001097, 32'h00001000, 3'd4, 1'b0, 32'h00002000);

        drive(32'h008000EF, 64'hFFFFFFFC);
        tick();
        chk_a("jal_wrap", 32'h008000EF, 32'h00000008, 3'd5, 1'b0, 32'h00000004);
        check("jal_wrap.d64_tgt", d_out_target, 64'h00000001_00000004);

        drive(32'hFE112C23, 64'h0);
        tick();
        chk_a("sw", 32'hFE112C23, 32'hFFFFFFF8, 3'd2, 1'b0, 32'h0);

        drive(32'h002081B3, 64'h0);
        tick();
        chk_a("add", 32'h002081B3, 32'h0, 3'd0, 1'b0, 32'h0);

        drive(32'h7FF00083, 64'h0);
        tick();
        chk_a("lb_max", 32'h7FF00083, 32'h000007FF, 3'd1, 1'b0, 32'h0);

        in_valid = 1'b0;
        tick();
        check("drain.valid", 64'(a_out_valid), 64'd0);
        check("drain.s0_valid", 64'(s_out_valid), 64'd0);

        // Stall: three inputs offered while out_ready=0 for 4 cycles
        out_ready = 1'b0;
        drive(32'h00100093, 64'h0);
        #1;
        check("stall.ready0", 64'(a_in_ready), 64'd1);
        tick();
        check("stall.a_inst",   64'(a_out_inst), 64'h00100093);
        check("stall.ready1",   64'(a_in_ready), 64'd1);
        check("stall.s0_ready", 64'(s_in_ready), 64'd0);
        drive(32'h00200093, 64'h0);
        tick();
        check("stall.ready2", 64'(a_in_ready), 64'd0);
        check("stall.hold2",  64'(a_out_inst), 64'h00100093);
        drive(32'h00300093, 64'h0);
        tick();
        check("stall.ready3", 64'(a_in_ready), 64'd0);
        check("stall.hold3",  64'(a_out_inst), 64'h00100093);
        tick();
        check("stall.hold4",  64'(a_out_inst), 64'h00100093);
        check("stall.imm4",   64'(a_out_imm),  64'h1);
        check("stall.valid4", 64'(a_out_valid), 64'd1);
        check("stall.s0_hold", 64'(s_out_inst), 64'h00100093);

        out_ready = 1'b1;
        tick();
        check("release.b_inst", 64'(a_out_inst), 64'h00200093);
        check("release.ready",  64'(a_in_ready), 64'd1);
        check("release.s0_reload", 64'(s_out_inst), 64'h00300093);
        tick();
        in_valid = 1'b0;
        check("release.c_inst",  64'(a_out_inst),  64'h00300093);
        check("release.c_imm",   64'(a_out_imm),   64'h3);
        check("release.c_valid", 64'(a_out_valid), 64'd1);
        tick();
        check("release.empty", 64'(a_out_valid), 64'd0);

        // Reset with both entries full
        out_ready = 1'b0;
        drive(32'h00400093, 64'h0);
        tick();
        drive(32'h00500093, 64'h0);
        tick();
        check("full.ready", 64'(a_in_ready), 64'd0);
        drive(32'h00600093, 64'h0);
        rst = 1'b1;
        #1;
        check("rst2.ready_during", 64'(a_in_ready), 64'd0);
        tick();
        check("rst2.valid", 64'(a_out_valid), 64'd0);
        check("rst2.ready", 64'(a_in_ready),  64'd0);
        check("rst2.inst",  64'(a_out_inst),  64'd0);
        check("rst2.imm",   64'(a_out_imm),   64'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst2.ready_after", 64'(a_in_ready), 64'd1);
        tick();
        check("rst2.no_old1", 64'(a_out_valid), 64'd0);
        tick();
        check("rst2.no_old2", 64'(a_out_valid), 64'd0);
        check("rst2.d64_none", 64'(d_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
